// File: rtl/row_mem_2_pe_reader.sv
// row_mem_2_pe_reader: walks oc/kx/x over the row mems and tags the returned data for the PE array
// Ports: clk/resetn (async, active-low); start pulses a pass using OC, IMG_W, K (latched at start);
//        pe_ready gates reads; act_/weight_rd_en/addr drive the row mems; pe_valid/first/last/oc
//        describe the data arriving at the PEs one cycle later; busy is high outside IDLE; done pulses at the end.
module row_mem_2_pe_reader #(
   parameter int INPUT_BW            = 8,
   parameter int IA_ROW_MEM_ADDR     = 6,
   parameter int WEIGHT_ROW_MEM_ADDR = 7
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           start,
   input  logic [5:0]                     OC,
   input  logic [5:0]                     IMG_W,
   input  logic [2:0]                     K,
   input  logic                           pe_ready,
   output logic                           act_rd_en,
   output logic [IA_ROW_MEM_ADDR-1:0]     act_rd_addr,
   output logic                           weight_rd_en,
   output logic [WEIGHT_ROW_MEM_ADDR-1:0] weight_rd_addr,
   output logic                           pe_valid,
   output logic                           pe_first,
   output logic                           pe_last,
   output logic [5:0]                     pe_oc,
   output logic                           busy,
   output logic                           done
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_next;
   logic [5:0] r_oc_n, r_imgw, r_x, r_oc, r_pe_oc;
   logic [2:0] r_k, r_kx;
   logic       r_pe_valid, r_pe_first, r_pe_last;
   logic       w_rd, w_x_end, w_kx_end, w_oc_end, w_zero;
   logic [6:0] w_act_sum;
   logic [9:0] w_wt_sum;

   if (INPUT_BW < 1) begin : g_bw_check
      $error("INPUT_BW must be positive");
   end

   assign w_rd      = (r_state == S_READ) & pe_ready;
   assign w_x_end   = r_x == r_imgw - 6'd1;
   assign w_kx_end  = r_kx == r_k - 3'd1;
   assign w_oc_end  = r_oc == r_oc_n - 6'd1;
   assign w_zero    = (OC == 6'd0) | (IMG_W == 6'd0) | (K == 3'd0);
   assign w_act_sum = {1'b0, r_x} + {4'b0, r_kx};
   assign w_wt_sum  = 10'(r_oc) * 10'(r_k) + 10'(r_kx);

   assign act_rd_en      = w_rd;
   assign weight_rd_en   = w_rd;
   // Addresses are parked at 0 outside READ but held (not zeroed) during a pe_ready stall.
   assign act_rd_addr    = (r_state == S_READ) ? IA_ROW_MEM_ADDR'(w_act_sum) : '0;
   assign weight_rd_addr = (r_state == S_READ) ? WEIGHT_ROW_MEM_ADDR'(w_wt_sum) : '0;
   assign pe_valid       = r_pe_valid;
   assign pe_first       = r_pe_first;
   assign pe_last        = r_pe_last;
   assign pe_oc          = r_pe_oc;
   assign busy           = r_state != S_IDLE;
   assign done           = r_state == S_DONE;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? (w_zero ? S_DONE : S_READ) : S_IDLE;
         S_READ:  w_next = (w_rd && w_x_end && w_kx_end && w_oc_end) ? S_DRAIN : S_READ;
         S_DRAIN: w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_oc_n <= '0;
         r_imgw <= '0;
         r_k    <= '0;
         r_x    <= '0;
         r_kx   <= '0;
         r_oc   <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_oc_n <= OC;
         r_imgw <= IMG_W;
         r_k    <= K;
         r_x    <= '0;
         r_kx   <= '0;
         r_oc   <= '0;
      end else if (w_rd) begin
         r_x  <= w_x_end ? 6'd0 : r_x + 6'd1;
         r_kx <= w_x_end ? (w_kx_end ? 3'd0 : r_kx + 3'd1) : r_kx;
         r_oc <= (w_x_end && w_kx_end) ? r_oc + 6'd1 : r_oc;
      end
   end

   // Row mems return data one cycle after the read, so the tags ride one register behind.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pe_valid <= 1'b0;
         r_pe_first <= 1'b0;
         r_pe_last  <= 1'b0;
         r_pe_oc    <= '0;
      end else begin
         r_pe_valid <= w_rd;
         r_pe_first <= w_rd & (r_kx == 3'd0);
         r_pe_last  <= w_rd & w_kx_end;
         r_pe_oc    <= w_rd ? r_oc : 6'd0;
      end
   end
endmodule

// File: tb/tb_row_mem_2_pe_reader.sv
// tb_row_mem_2_pe_reader: scoreboard bench for row_mem_2_pe_reader
module tb_row_mem_2_pe_reader;
   localparam int IA = 6;
   localparam int WA = 7;
   logic          clk = 0, resetn = 0, start = 0, pe_ready = 1;
   logic [5:0]    OC = 0, IMG_W = 0;
   logic [2:0]    K = 0;
   logic          act_rd_en, weight_rd_en, pe_valid, pe_first, pe_last, busy, done;
   logic [IA-1:0] act_rd_addr;
   logic [WA-1:0] weight_rd_addr;
   logic [5:0]    pe_oc;

   typedef struct {int a; int w;} rd_t;
   typedef struct {int f; int l; int oc;} pe_t;
   rd_t rdq[$];
   pe_t peq[$];
   int  exp_done = 0;
   int  checks = 0, failures = 0;

   row_mem_2_pe_reader #(.INPUT_BW(8), .IA_ROW_MEM_ADDR(IA), .WEIGHT_ROW_MEM_ADDR(WA)) dut (
      .clk(clk), .resetn(resetn), .start(start), .OC(OC), .IMG_W(IMG_W), .K(K),
      .pe_ready(pe_ready), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
      .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr), .pe_valid(pe_valid),
      .pe_first(pe_first), .pe_last(pe_last), .pe_oc(pe_oc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Reference: every pass is the plain triple loop oc/kx/x with modular addresses.
   task automatic model(input int oc, input int w, input int k);
      for (int o = 0; o < oc; o++)
         for (int kx = 0; kx < k; kx++)
            for (int x = 0; x < w; x++) begin
               rdq.push_back('{(x + kx) % (1 << IA), (o * k + kx) % (1 << WA)});
               peq.push_back('{int'(kx == 0), int'(kx == k - 1), o});
            end
   endtask

   always @(negedge clk) begin
      chk("weight_en_eq_act_en", int'(weight_rd_en), int'(act_rd_en));
      if (!busy)
         chk("idle_quiet", int'(act_rd_en) + int'(act_rd_addr != 0) + int'(weight_rd_addr != 0) + int'(pe_valid), 0);
      if (act_rd_en) begin
         if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            rd_t r;
            r = rdq.pop_front();
            chk("act_rd_addr", int'(act_rd_addr), r.a);
            chk("weight_rd_addr", int'(weight_rd_addr), r.w);
         end
      end
      if (pe_valid) begin
         if (peq.size() == 0) chk("pe_unexpected", 1, 0);
         else begin
            pe_t p;
            p = peq.pop_front();
            chk("pe_first", int'(pe_first), p.f);
            chk("pe_last", int'(pe_last), p.l);
            chk("pe_oc", int'(pe_oc), p.oc);
         end
      end
      if (done) begin
         chk("done_expected", int'(exp_done > 0), 1);
         if (exp_done > 0) exp_done--;
         chk("done_rdq_empty", rdq.size(), 0);
         chk("done_peq_empty", peq.size(), 0);
      end
   end

   // mode 0: always ready, 1: random ready plus a stray start, 2: three-cycle stall while the 5th read is presented
   task automatic run_pass(input int oc, input int w, input int k, input int mode);
      int n, cyc, busy_cnt, reads, stall_left, exp_lat;
      bit got;
      n = oc * w * k;
      model(oc, w, k);
      exp_done++;
      pe_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1; OC = 6'(oc); IMG_W = 6'(w); K = 3'(k);
      @(posedge clk); #1;
      start = 0; OC = 6'($urandom); IMG_W = 6'($urandom); K = 3'($urandom);
      cyc = 0; busy_cnt = 0; reads = 0; stall_left = 3; got = 0;
      while (!got && cyc < 4 * n + 40) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         if (act_rd_en) reads++;
         if (mode == 2 && !pe_ready) begin
            chk("stall_rd_en", int'(act_rd_en), 0);
            chk("stall_act_addr", int'(act_rd_addr), 1);
            chk("stall_weight_addr", int'(weight_rd_addr), 1);
         end
         if (done) got = 1;
         else begin
            @(posedge clk); #1;
            start = (mode == 1 && cyc == 2 && n >= 6);
            if (mode == 1) pe_ready = $urandom_range(0, 3) != 0;
            else if (mode == 2 && reads == 4 && stall_left > 0) begin
               pe_ready = 0;
               stall_left--;
            end else pe_ready = 1;
         end
      end
      start = 0;
      if (!got) begin
         chk("done_timeout", 0, 1);
         resetn = 0;
         #1;
         rdq.delete(); peq.delete(); exp_done = 0;
         @(posedge clk); #1 resetn = 1;
      end else begin
         exp_lat = (n == 0) ? 1 : n + 2 + ((mode == 2) ? 3 : 0);
         if (mode != 1) chk("done_latency", cyc, exp_lat);
         if (mode == 0) chk("busy_cycles", busy_cnt, exp_lat);
         @(posedge clk); #1;
         @(negedge clk);
         chk("done_single_cycle", int'(done), 0);
         chk("busy_after_done", int'(busy), 0);
      end
      pe_ready = 1;
   endtask

   task automatic reset_mid();
      int reads, cyc;
      model(2, 4, 3);
      exp_done++;
      pe_ready = 1;
      start = 1; OC = 2; IMG_W = 4; K = 3;
      @(posedge clk); #1 start = 0;
      reads = 0; cyc = 0;
      while (reads < 10 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (act_rd_en) reads++;
         @(posedge clk); #1;
      end
      chk("reads_before_reset", reads, 10);
      exp_done = 0;
      resetn = 0;
      #1;
      chk("rst_rd_en", int'(act_rd_en) + int'(weight_rd_en), 0);
      chk("rst_addrs", int'(act_rd_addr) + int'(weight_rd_addr), 0);
      chk("rst_pe", int'(pe_valid) + int'(pe_first) + int'(pe_last) + int'(pe_oc), 0);
      chk("rst_busy_done", int'(busy) + int'(done), 0);
      rdq.delete(); peq.delete();
      repeat (3) @(posedge clk);
      #1 resetn = 1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_rd_en", int'(act_rd_en), 0);
      chk("reset_pe_valid", int'(pe_valid), 0);
      resetn = 1;
      @(posedge clk); #1;
      run_pass(2, 4, 3, 0);
      run_pass(2, 4, 3, 2);
      run_pass(3, 2, 1, 0);
      run_pass(0, 5, 3, 0);
      reset_mid();
      run_pass(2, 4, 3, 0);
      run_pass(2, 63, 4, 0);
      run_pass(40, 1, 4, 0);
      for (int i = 0; i < 12; i++)
         run_pass($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 5), 1);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
